// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for serial_addsub.
// The producer/consumer side uses the master modport, the arithmetic block uses slave.
// The ovf line exists only when SERIAL_ADDSUB_OVF_EN is defined.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, sub, out_ready,
`ifdef SERIAL_ADDSUB_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, result, cout, busy
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
`ifdef SERIAL_ADDSUB_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, result, cout, busy
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one carry/borrow flip-flop.
// One operand set is accepted in IDLE, WIDTH RUN cycles process one bit each,
// and the result is held in DONE until the consumer takes it.
// Optional signed-overflow output: define SERIAL_ADDSUB_OVF_EN.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  serial_addsub_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic aBit, bBit, halfX, genTerm, propTerm, bitOut, carryNext;

  // Per-bit cell: half-add/half-sub terms combined into a full adder or subtractor
  always_comb begin
    aBit      = aSh_q[0];
    bBit      = bSh_q[0];
    halfX     = aBit ^ bBit;
    genTerm   = sub_q ? (~aBit & bBit) : (aBit & bBit);
    propTerm  = sub_q ? (~halfX & carry_q) : (halfX & carry_q);
    bitOut    = halfX ^ carry_q;
    carryNext = genTerm | propTerm;
  end

  // Next-state and datapath updates for the IDLE -> RUN -> DONE sequence
  always_comb begin
    state_d  = state_q;
    aSh_d    = aSh_q;
    bSh_d    = bSh_q;
    sub_d    = sub_q;
    result_d = result_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          aSh_d   = bus.a;
          bSh_d   = bus.b;
          sub_d   = bus.sub;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        aSh_d    = {1'b0, aSh_q[WIDTH-1:1]};
        bSh_d    = {1'b0, bSh_q[WIDTH-1:1]};
        result_d = {bitOut, result_q[WIDTH-1:1]};
        carry_d  = carryNext;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          cout_d  = carryNext;
`ifdef SERIAL_ADDSUB_OVF_EN
          ovf_d   = carry_q ^ carryNext;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      aSh_q    <= '0;
      bSh_q    <= '0;
      sub_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      aSh_q    <= aSh_d;
      bSh_q    <= bSh_d;
      sub_q    <= sub_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub at WIDTH=8.
// Checks ovf only when SERIAL_ADDSUB_OVF_EN is defined.
module tb_serial_addsub;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  serial_addsub_if #(.WIDTH(WIDTH)) bus ();

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full operation: present operands, check latency, result and release
  task automatic applyStimulus(input string tag, input logic [7:0] opA,
                               input logic [7:0] opB, input logic opSub,
                               input logic [7:0] expRes, input logic expCout,
                               input logic expOvf, input bit scramble);
    int n;
    int rdyViol;
    n       = 0;
    rdyViol = 0;
    checkOutput({tag, "_idle_rdy"}, 32'(bus.in_ready), 32'd1);
    bus.a        = opA;
    bus.b        = opB;
    bus.sub      = opSub;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && n < 20) begin
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) rdyViol++;
      if (scramble) begin
        bus.a   = 8'($urandom);
        bus.b   = 8'($urandom);
        bus.sub = ~bus.sub;
      end
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, "_latency"}, 32'(n), 32'd8);
    checkOutput({tag, "_run_flags"}, 32'(rdyViol), 32'd0);
    checkOutput({tag, "_result"}, 32'(bus.result), 32'(expRes));
    checkOutput({tag, "_cout"}, 32'(bus.cout), 32'(expCout));
`ifdef SERIAL_ADDSUB_OVF_EN
    checkOutput({tag, "_ovf"}, 32'(bus.ovf), 32'(expOvf));
`else
    if (expOvf === 1'bx) rdyViol++;
`endif
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, "_back_idle"}, 32'({bus.in_ready, bus.out_valid}), 32'b10);
  endtask

  // Directed scenario sequence
  initial begin
    int accIdx;
    int resIdx;
    int accCyc [3];
    logic [7:0] bA [3];
    logic [7:0] bB [3];
    logic       bS [3];
    logic [7:0] bR [3];

    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;

    // Reset state
    #12;
    checkOutput("rst_state", 32'({bus.in_ready, bus.out_valid, bus.busy, bus.cout}), 32'b1000);
    checkOutput("rst_result", 32'(bus.result), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Arithmetic vectors including wrap and borrow boundaries
    applyStimulus("add_5a_33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, 1'b0);
    applyStimulus("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus("sub_00_01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    applyStimulus("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0);
    applyStimulus("sub_3c_3c", 8'h3C, 8'h3C, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

    // Inputs scrambled while the op is in flight
    applyStimulus("scramble", 8'hA5, 8'h5A, 1'b1, 8'h4B, 1'b0, 1'b1, 1'b1);

    // Backpressure in DONE with in_valid pulsing and operands moving
    bus.a = 8'h12; bus.b = 8'h34; bus.sub = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.out_valid; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.a = 8'(i * 37);
      bus.b = 8'(i * 11 + 3);
      @(posedge clk); #1;
      checkOutput($sformatf("bp_hold%0d", i),
                  32'({bus.out_valid, bus.in_ready, bus.cout, bus.result}),
                  32'({1'b1, 1'b0, 1'b0, 8'h46}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput("bp_release", 32'({bus.in_ready, bus.out_valid}), 32'b10);

    // Back-to-back with in_valid held high and out_ready held high
    bA = '{8'h01, 8'hF0, 8'h7F};
    bB = '{8'h02, 8'h0F, 8'h01};
    bS = '{1'b0, 1'b1, 1'b0};
    bR = '{8'h03, 8'hE1, 8'h80};
    accIdx = 0;
    resIdx = 0;
    bus.a = bA[0]; bus.b = bB[0]; bus.sub = bS[0];
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && resIdx < 3; cyc++) begin
      bit acceptNow;
      acceptNow = bus.in_ready && bus.in_valid;
      if (bus.out_valid && resIdx < 3) begin
        checkOutput($sformatf("b2b_res%0d", resIdx), 32'(bus.result), 32'(bR[resIdx]));
        resIdx++;
      end
      if (acceptNow) begin
        accCyc[accIdx] = cyc;
        accIdx++;
      end
      @(posedge clk); #1;
      if (acceptNow) begin
        if (accIdx < 3) begin
          bus.a = bA[accIdx]; bus.b = bB[accIdx]; bus.sub = bS[accIdx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checkOutput("b2b_accepts", 32'(accIdx), 32'd3);
    checkOutput("b2b_results", 32'(resIdx), 32'd3);
    if (accIdx == 3) begin
      checkOutput("b2b_gap01", 32'(accCyc[1] - accCyc[0]), 32'd10);
      checkOutput("b2b_gap12", 32'(accCyc[2] - accCyc[1]), 32'd10);
    end
    @(posedge clk); #1;

    // Asynchronous reset in the middle of RUN
    bus.a = 8'h55; bus.b = 8'h0F; bus.sub = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_flags", 32'({bus.in_ready, bus.out_valid, bus.busy, bus.cout}), 32'b1000);
    checkOutput("midrst_result", 32'(bus.result), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
